counter_input_conditioner: RTL and testbench

COUNTER_INPUT_CONDITIONER -- requirements
Module: counter_input_conditioner

---
 rtl/counter_input_conditioner.sv | 86 ++++++++
 tb/tb_counter_input_conditioner.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/counter_input_conditioner.sv
// Push-button conditioner: a two-flop synchronizer, then a per-channel debounce counter.
// Emits a debounced level and a single-cycle rise/fall pulse on each accepted change.
module counter_input_conditioner #(
   parameter int N_CH            = 4,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            ena,
   input  logic [N_CH-1:0] btn_in,
   output logic [N_CH-1:0] btn_level,
   output logic [N_CH-1:0] btn_rise,
   output logic [N_CH-1:0] btn_fall
);

   localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [N_CH-1:0] sync1_q;
   logic [N_CH-1:0] sync2_q;

   // The synchronizer runs every cycle, so a frozen channel still sees fresh input on resume.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= btn_in;
         sync2_q <= sync1_q;
      end
   end

   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         logic [CW-1:0] cnt_q;
         logic [CW-1:0] cnt_d;
         logic          level_q;
         logic          level_d;
         logic          rise_q;
         logic          rise_d;
         logic          fall_q;
         logic          fall_d;

         always_comb begin
            cnt_d   = cnt_q;
            level_d = level_q;
            rise_d  = 1'b0;
            fall_d  = 1'b0;
            if (ena) begin
               if (sync2_q[gi] != level_q) begin
                  if (cnt_q == CNT_MAX) begin
                     level_d = sync2_q[gi];
                     cnt_d   = '0;
                     rise_d  = sync2_q[gi];
                     fall_d  = ~sync2_q[gi];
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else begin
                  // Any agreement with the held level restarts the count.
                  cnt_d = '0;
               end
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               cnt_q   <= '0;
               level_q <= 1'b0;
               rise_q  <= 1'b0;
               fall_q  <= 1'b0;
            end else begin
               cnt_q   <= cnt_d;
               level_q <= level_d;
               rise_q  <= rise_d;
               fall_q  <= fall_d;
            end
         end

         assign btn_level[gi] = level_q;
         assign btn_rise[gi]  = rise_q;
         assign btn_fall[gi]  = fall_q;
      end
   endgenerate

endmodule

// File: tb/tb_counter_input_conditioner.sv
// Directed bench for counter_input_conditioner at DEBOUNCE_CYCLES=4, N_CH=4.
// Outputs are sampled 1 time unit after each rising edge.
module tb_counter_input_conditioner;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [3:0] btn_in;
   logic [3:0] btn_level;
   logic [3:0] btn_rise;
   logic [3:0] btn_fall;

   int checks;
   int errors;

   counter_input_conditioner #(
      .N_CH           (4),
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .ena      (ena),
      .btn_in   (btn_in),
      .btn_level(btn_level),
      .btn_rise (btn_rise),
      .btn_fall (btn_fall)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge; calling this k+1 times lands just after edge k.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [3:0] lvl,
                             input logic [3:0] rise, input logic [3:0] fall);
      checks++;
      if (btn_level !== lvl || btn_rise !== rise || btn_fall !== fall) begin
         errors++;
         $display("FAIL %s: level=%h rise=%h fall=%h, required level=%h rise=%h fall=%h",
                  name, btn_level, btn_rise, btn_fall, lvl, rise, fall);
      end else begin
         $display("ok   %s: level=%h rise=%h fall=%h", name, btn_level, btn_rise, btn_fall);
      end
   endtask

   task automatic test_reset();
      ena    = 1'b1;
      btn_in = 4'hF;
      rst    = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      // Time 3: no clock edge has occurred yet, so the clear must be asynchronous.
      expect_out("reset_async", 4'h0, 4'h0, 4'h0);
      btn_in = 4'h0;
      tick();
      tick();
      expect_out("reset_held", 4'h0, 4'h0, 4'h0);
      rst = 1'b0;
      repeat (4) tick();
      expect_out("idle_after_reset", 4'h0, 4'h0, 4'h0);
   endtask

   task automatic test_press();
      btn_in = 4'h1;
      repeat (5) tick();
      expect_out("press_edge4", 4'h0, 4'h0, 4'h0);
      tick();
      expect_out("press_edge5", 4'h1, 4'h1, 4'h0);
      tick();
      expect_out("press_edge6", 4'h1, 4'h0, 4'h0);
   endtask

   task automatic test_release();
      btn_in = 4'h0;
      repeat (5) tick();
      expect_out("release_edge4", 4'h1, 4'h0, 4'h0);
      tick();
      expect_out("release_edge5", 4'h0, 4'h0, 4'h1);
      tick();
      expect_out("release_edge6", 4'h0, 4'h0, 4'h0);
   endtask

   task automatic test_bounce();
      btn_in = 4'h2;
      tick();
      btn_in = 4'h0;
      tick();
      btn_in = 4'h2;
      tick();
      btn_in = 4'h0;
      for (int i = 0; i < 8; i++) begin
         tick();
         expect_out($sformatf("bounce_cyc%0d", i), 4'h0, 4'h0, 4'h0);
      end
   endtask

   task automatic test_freeze();
      btn_in = 4'h4;
      repeat (4) tick();
      expect_out("freeze_edge3", 4'h0, 4'h0, 4'h0);
      ena = 1'b0;
      for (int i = 0; i < 10; i++) begin
         tick();
         expect_out($sformatf("freeze_hold%0d", i), 4'h0, 4'h0, 4'h0);
      end
      ena = 1'b1;
      tick();
      expect_out("freeze_resume1", 4'h0, 4'h0, 4'h0);
      tick();
      expect_out("freeze_resume2", 4'h4, 4'h4, 4'h0);
      tick();
      expect_out("freeze_after", 4'h4, 4'h0, 4'h0);
      btn_in = 4'h0;
      repeat (6) tick();
      expect_out("freeze_release", 4'h0, 4'h0, 4'h4);
      tick();
   endtask

   task automatic test_simultaneous();
      btn_in = 4'hA;
      repeat (5) tick();
      expect_out("simul_edge4", 4'h0, 4'h0, 4'h0);
      tick();
      expect_out("simul_edge5", 4'hA, 4'hA, 4'h0);
      tick();
      expect_out("simul_edge6", 4'hA, 4'h0, 4'h0);
      btn_in = 4'h0;
      repeat (6) tick();
      expect_out("simul_fall", 4'h0, 4'h0, 4'hA);
      tick();
      expect_out("simul_fall_end", 4'h0, 4'h0, 4'h0);
   endtask

   task automatic test_reset_midcount();
      btn_in = 4'h1;
      repeat (4) tick();
      rst = 1'b1;
      #2;
      expect_out("midcount_reset", 4'h0, 4'h0, 4'h0);
      rst = 1'b0;
      repeat (5) tick();
      expect_out("midcount_edge4", 4'h0, 4'h0, 4'h0);
      tick();
      expect_out("midcount_edge5", 4'h1, 4'h1, 4'h0);
      btn_in = 4'h0;
      repeat (7) tick();
      expect_out("midcount_cleanup", 4'h0, 4'h0, 4'h0);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_press();
      test_release();
      test_bounce();
      test_freeze();
      test_simultaneous();
      test_reset_midcount();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
